// File: rtl/bbot_encoder_pkg.sv
// Shared widths, channel ids and FSM states
// for the wheel encoder sampling controller.
package bbot_encoder_pkg;

  localparam int COUNT_W = 32;
  localparam int SEQ_W   = 8;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CALC,
    ST_OFFER_L,
    ST_OFFER_R
  } state_t;

endpackage

// File: rtl/bbot_encoder_sampler_timer.sv
// Free-running sample period timer with enable,
// synchronous restart and terminal-count tick.
module bbot_period_timer #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (restart || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bbot_encoder_sampler.sv
// Periodic snapshot of both wheel counters, per-period
// signed deltas offered one channel at a time.
import bbot_encoder_pkg::*;

module bbot_encoder_sampler #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [COUNT_W-1:0] count_left,
  input  logic [COUNT_W-1:0] count_right,
  input  logic               clear_req,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               sample_chan,
  output logic [COUNT_W-1:0] sample_delta,
  output logic [SEQ_W-1:0]   sample_seq,
  output logic               overrun,
  output logic               busy
);

  state_t state;

  logic [COUNT_W-1:0] prev_left;
  logic [COUNT_W-1:0] prev_right;
  logic [COUNT_W-1:0] snap_left;
  logic [COUNT_W-1:0] snap_right;
  logic [COUNT_W-1:0] delta_right;
  logic               clear_pending;
  logic               clear_apply;
  logic               tick;
  logic               idle;

  assign idle        = (state == ST_IDLE);
  assign clear_apply = idle && (clear_req || clear_pending);
  assign busy        = !idle;

  bbot_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .restart(clear_apply),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      prev_left     <= '0;
      prev_right    <= '0;
      snap_left     <= '0;
      snap_right    <= '0;
      delta_right   <= '0;
      clear_pending <= 1'b0;
      sample_valid  <= 1'b0;
      sample_chan   <= CHAN_LEFT;
      sample_delta  <= '0;
      sample_seq    <= '0;
      overrun       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // a clear outranks a tick in the same cycle
          if (clear_apply) begin
            prev_left     <= count_left;
            prev_right    <= count_right;
            sample_seq    <= '0;
            overrun       <= 1'b0;
            clear_pending <= 1'b0;
          end else if (tick) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          snap_left  <= count_left;
          snap_right <= count_right;
          state      <= ST_CALC;
        end
        ST_CALC: begin
          prev_left    <= snap_left;
          prev_right   <= snap_right;
          delta_right  <= snap_right - prev_right;
          sample_delta <= snap_left - prev_left;
          sample_chan  <= CHAN_LEFT;
          sample_valid <= 1'b1;
          state        <= ST_OFFER_L;
        end
        ST_OFFER_L: begin
          if (sample_ready) begin
            sample_delta <= delta_right;
            sample_chan  <= CHAN_RIGHT;
            state        <= ST_OFFER_R;
          end
        end
        ST_OFFER_R: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            sample_seq   <= sample_seq + SEQ_W'(1);
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // prev is untouched here, so dropped periods fold into the next pair
      if (!idle) begin
        if (tick) overrun <= 1'b1;
        if (clear_req) clear_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bbot_encoder_sampler.sv
// Directed bench for bbot_encoder_sampler with a
// cycle-level behavioural model and literal checks.
module tb_bbot_encoder_sampler;

  localparam int P = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] count_left = '0;
  logic [31:0] count_right = '0;
  logic        clear_req = 1'b0;
  logic        sample_ready = 1'b1;
  logic        sample_valid;
  logic        sample_chan;
  logic [31:0] sample_delta;
  logic [7:0]  sample_seq;
  logic        overrun;
  logic        busy;

  bbot_encoder_sampler #(.PERIOD_CYCLES(P)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .count_left  (count_left),
    .count_right (count_right),
    .clear_req   (clear_req),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_chan (sample_chan),
    .sample_delta(sample_delta),
    .sample_seq  (sample_seq),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  seq;
    logic        chan;
    logic [31:0] delta;
  } xfer_t;
  xfer_t xlog[$];

  // Model: timer as elapsed cycles, pair progress as a stage number
  int          m_cnt;
  int          m_stage;
  logic [31:0] m_prev_l, m_prev_r, m_snap_l, m_snap_r;
  logic [31:0] m_dl, m_dr;
  logic [7:0]  m_seq;
  bit          m_ovr, m_pend, m_tk, m_clr;

  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0; m_stage = 0; m_seq = 0; m_ovr = 0; m_pend = 0;
      m_prev_l = 0; m_prev_r = 0;
    end else begin
      if (sample_valid && sample_ready)
        xlog.push_back('{sample_seq, sample_chan, sample_delta});
      m_tk  = enable && (m_cnt == P - 1);
      m_clr = (m_stage == 0) && (clear_req || m_pend);
      m_cnt = (m_clr || !enable || m_tk) ? 0 : m_cnt + 1;
      if (m_stage == 0) begin
        if (m_clr) begin
          m_prev_l = count_left; m_prev_r = count_right;
          m_seq = 0; m_ovr = 0; m_pend = 0;
        end else if (m_tk) m_stage = 1;
      end else begin
        if (m_tk) m_ovr = 1;
        if (clear_req) m_pend = 1;
        case (m_stage)
          1: begin
            m_snap_l = count_left; m_snap_r = count_right; m_stage = 2;
          end
          2: begin
            m_dl = m_snap_l - m_prev_l; m_dr = m_snap_r - m_prev_r;
            m_prev_l = m_snap_l; m_prev_r = m_snap_r; m_stage = 3;
          end
          3: if (sample_ready) m_stage = 4;
          default: if (sample_ready) begin m_stage = 0; m_seq++; end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (chk && !reset) begin
      cmp("valid", 32'(sample_valid), 32'(m_stage >= 3));
      cmp("busy", 32'(busy), 32'(m_stage != 0));
      cmp("overrun", 32'(overrun), 32'(m_ovr));
      if (m_stage >= 3) begin
        cmp("chan", 32'(sample_chan), 32'(m_stage == 4));
        cmp("delta", sample_delta, (m_stage == 3) ? m_dl : m_dr);
        cmp("seq", 32'(sample_seq), 32'(m_seq));
      end
    end
  end

  task automatic wait_log(int n);
    int t = 0;
    while (xlog.size() < n && t < 300) begin
      @(negedge clock); t++;
    end
    if (xlog.size() < n) begin
      n_bad++; n_cmp++;
      $display("FAIL wait_log: got %0d transfers want %0d", xlog.size(), n);
      while (xlog.size() < n) xlog.push_back('{8'hxx, 1'bx, 32'hxxxxxxxx});
    end
  endtask

  task automatic wait_offer(bit right);
    int t = 0;
    do begin
      @(negedge clock); t++;
    end while (!(sample_valid && sample_chan == right) && t < 300);
    if (!(sample_valid && sample_chan == right)) begin
      n_bad++; n_cmp++;
      $display("FAIL wait_offer: no offer on chan %0d", right);
    end
  endtask

  int k, n, seen;

  initial begin
    repeat (2) @(negedge clock);
    cmp("rst_valid", 32'(sample_valid), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_seq", 32'(sample_seq), 0);
    cmp("rst_ovr", 32'(overrun), 0);
    cmp("rst_chan", 32'(sample_chan), 0);
    cmp("rst_delta", sample_delta, 0);
    chk = 1;
    reset = 0;
    enable = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      count_left = 32'(20 * i);
      count_right = -32'(i);
    end
    wait_log(4);
    cmp("p0_seq", 32'(xlog[0].seq), 0);
    cmp("p0_chan", 32'(xlog[0].chan), 0);
    cmp("p0_left", xlog[0].delta, 32'd100);
    cmp("p0_chan_r", 32'(xlog[1].chan), 1);
    cmp("p0_right", xlog[1].delta, 32'hFFFFFFFB);
    cmp("p1_seq", 32'(xlog[2].seq), 1);
    cmp("p1_left", xlog[2].delta, 0);
    cmp("p1_right", xlog[3].delta, 0);

    count_left = 32'hFFFFFFF0;
    wait_log(6);
    cmp("pre_wrap", xlog[4].delta, 32'hFFFFFF8C);
    count_left = 32'h00000010;
    wait_log(8);
    cmp("wrap_left", xlog[6].delta, 32'h00000020);

    k = xlog.size();
    wait_offer(0);
    sample_ready = 0;
    count_left = 32'h0000013C;
    count_right = 32'hFFFFFFC9;
    repeat (25) @(negedge clock);
    cmp("bp_overrun", 32'(overrun), 1);
    sample_ready = 1;
    wait_log(k + 4);
    cmp("bp_stall_l", xlog[k].delta, 0);
    cmp("bp_acc_l", xlog[k + 2].delta, 32'd300);
    cmp("bp_acc_r", xlog[k + 3].delta, 32'hFFFFFFCE);

    k = xlog.size();
    count_left = count_left + 40;
    count_right = count_right + 60;
    wait_offer(0);
    clear_req = 1;
    count_left = count_left + 1000;
    @(negedge clock);
    clear_req = 0;
    wait_log(k + 2);
    cmp("clr_keep_l", xlog[k].delta, 32'd40);
    cmp("clr_keep_r", xlog[k + 1].delta, 32'd60);
    repeat (2) @(negedge clock);
    cmp("clr_seq", 32'(sample_seq), 0);
    cmp("clr_ovr", 32'(overrun), 0);
    wait_log(k + 4);
    cmp("clr_next_seq", 32'(xlog[k + 2].seq), 0);
    cmp("clr_next_l", xlog[k + 2].delta, 0);
    cmp("clr_next_r", xlog[k + 3].delta, 0);

    count_left = 32'h00001234;
    count_right = 32'h00000055;
    wait_offer(1);
    reset = 1;
    @(negedge clock);
    cmp("mid_rst_valid", 32'(sample_valid), 0);
    cmp("mid_rst_busy", 32'(busy), 0);
    cmp("mid_rst_seq", 32'(sample_seq), 0);
    reset = 0;
    k = xlog.size();
    wait_log(k + 2);
    cmp("post_rst_seq", 32'(xlog[k].seq), 0);
    cmp("post_rst_l", xlog[k].delta, 32'h00001234);
    cmp("post_rst_r", xlog[k + 1].delta, 32'h00000055);

    enable = 0;
    seen = 0;
    repeat (200) begin
      @(negedge clock);
      if (sample_valid || busy) seen++;
    end
    cmp("en_off_quiet", 32'(seen), 0);
    enable = 1;
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (!sample_valid && n < 100);
    cmp("en_latency", 32'(n), 32'(P + 2));
    wait_log(xlog.size() + 2);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bbot_encoder_sampler.md
# bbot_encoder_sampler

Periodic sampling controller for the two wheel quadrature counters. It snapshots both 32-bit running counts on a fixed period and computes signed per-period deltas (wheel velocity). It hands the deltas one channel at a time to the downstream consumer (balance/velocity loop or host register bridge) over a valid/ready handshake. It also sequences baseline clears and flags dropped periods.

## Interface
- PERIOD_CYCLES, 50000, sample period in clock cycles (1 kHz at 50 MHz); legal range 8 to 2^24.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = period timer runs; 0 = timer held at 0, no new ticks.
- count_left  in  32  running count from the left-wheel quadrature counter.
- count_right  in  32  running count from the right-wheel quadrature counter.
- clear_req  in  1  one-cycle pulse: re-baseline, zero seq, clear overrun, restart period.
- sample_valid  out  1  delta on sample_delta/sample_chan is offered.
- sample_ready  in  1  consumer accepts; transfer on a cycle with valid && ready.
- sample_chan  out  1  0 = left, 1 = right.
- sample_delta  out  32  signed delta for sample_chan (two's complement).
- sample_seq  out  8  index of the sample pair, wraps 255 -> 0.
- overrun  out  1  sticky; set when a tick arrives while not IDLE.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset values: state IDLE, period counter 0, sample_valid 0, sample_chan 0, sample_delta 0, sample_seq 0, overrun 0, busy 0, prev_left/prev_right 0, clear_pending 0.
- Period timer: counts 0..PERIOD_CYCLES-1 while enable is high and emits tick on the terminal-count cycle, then returns to 0. When enable is low, the counter is forced to 0.
- FSM states: IDLE, CAPTURE, CALC, OFFER_L, OFFER_R.
  - IDLE -> CAPTURE on tick.
  - CAPTURE: snap_left/right <= count_left/right, sampled together in the same cycle -> CALC.
  - CALC: delta_x <= snap_x - prev_x, modulo 2^32, so wrap-around is correct for |motion| < 2^31 per period. prev_x <= snap_x -> OFFER_L.
  - OFFER_L: valid=1, chan=0, delta=delta_left. On handshake -> OFFER_R.
  - OFFER_R: valid=1, chan=1, delta=delta_right. On handshake -> IDLE and sample_seq += 1.
- Tick while not IDLE: tick is dropped and overrun <= 1. Motion is not lost because prev only updates in CALC, so the next pair covers the elapsed periods.
- clear_req in IDLE, applied in the same cycle:
  - prev_x <= count_x.
  - period counter <= 0.
  - sample_seq <= 0, overrun <= 0.
  - clear beats a simultaneous tick, and that tick is discarded.
- clear_req while not IDLE: clear_pending <= 1. The in-flight pair completes unchanged, and the clear is applied on the first IDLE cycle, before any tick.
- enable falling mid-transaction: the current pair still completes.
- Reset mid-operation: abandons the pair. Next cycle is IDLE with valid 0 and all reset values.

## Timing
- Tick on cycle T -> CAPTURE at T+1 (latches count inputs present at T+1) -> CALC at T+2 -> sample_valid high from T+3.
- With ready held high: left transfers at T+3, right at T+4, IDLE at T+5.
- While valid is high and ready is low, sample_chan, sample_delta and sample_seq are held stable.
- valid never drops without a handshake, except on reset.
- Outputs are registered; there is no combinational path from sample_ready to sample_valid or data.
- Minimum cycles per pair: 5, hence PERIOD_CYCLES >= 8.

## Structure
- Package bbot_encoder_pkg holds:
  - COUNT_W = 32, SEQ_W = 8.
  - CHAN_LEFT = 0, CHAN_RIGHT = 1.
  - The FSM state enum.
- Sub-module bbot_period_timer: PERIOD_CYCLES counter with enable, synchronous restart (driven by clear) and a tick output.
- The FSM, snapshot/prev registers and handshake stay in the top module.

## Test plan
- PERIOD_CYCLES=10, ready=1, left ramps 0->100, right 0->0xFFFFFFFB before the first tick -> pair seq 0: left +100, right -5 (0xFFFFFFFB). With counts static, the next pair is seq 1: 0, 0.
- Wrap: prev_left 0xFFFFFFF0, count_left 0x00000010 at capture -> sample_delta 0x00000020.
- Backpressure: PERIOD_CYCLES=10, ready low for 25 cycles during OFFER_L -> valid/data/chan stable throughout, overrun=1. The following pair reports motion accumulated across the skipped periods.
- clear_req pulsed during OFFER_L -> both deltas of the current pair delivered unchanged. Then seq=0, overrun=0, period restarts. Stationary wheels give next deltas 0, 0.
- reset asserted one cycle during OFFER_R -> following cycle valid=0, busy=0, seq=0, prev=0. The first post-reset pair reports the full counts.
- enable=0 for 200 cycles -> no sample_valid, busy=0. After enable=1, first valid appears PERIOD_CYCLES+2 cycles later.
